// File: rtl/alu_decode_pipe.sv
// alu_decode_pipe: registered MIPS instruction -> ALU control decode stage.
// Instructions arrive on a valid/ready handshake. Each one is decoded
// combinationally and then captured into a two-entry buffer: an output
// register followed by a skid register. The skid register lets upstream run
// at full throughput without losing an instruction when execute stalls.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o   upstream handshake; ready = skid register empty
//   instr_i                 32-bit MIPS instruction
//   flush_i                 synchronous kill of all buffered entries
//   out_valid_o/out_ready_i execute-stage handshake
//   alu_ctrl_o .. illegal_o decoded controls of the entry at the head
//   illegal_cnt_o           saturating count of accepted illegal instructions
//
// state   | meaning
// --------+------------------------------------------------
// S_EMPTY | nothing buffered, out_valid_o = 0
// S_ONE   | output register full, skid register empty
// S_FULL  | both registers full, in_ready_o = 0
module alu_decode_pipe #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [3:0]       alu_ctrl_o,
   output logic             alu_src_o,
   output logic             shamt_sel_o,
   output logic             reg_write_o,
   output logic             branch_o,
   output logic [1:0]       branch_type_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   typedef struct packed {
      logic [3:0] ctrl;
      logic       alu_src;
      logic       shamt_sel;
      logic       reg_write;
      logic       branch;
      logic [1:0] btype;
      logic       illegal;
   } dec_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   dec_t             dec;
   dec_t             out_q, out_d;
   dec_t             skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             consume;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             instr_unused;

   assign opcode       = instr_i[31:26];
   assign funct        = instr_i[5:0];
   assign instr_unused = ^instr_i[25:6];

   assign accept  = in_valid_i & in_ready_o;
   assign consume = out_valid_o & out_ready_i;

   always_comb begin
      dec = '0;
      unique case (opcode)
         6'h00: begin
            dec.reg_write = 1'b1;
            unique case (funct)
               6'h20: dec.ctrl = 4'd2;
               6'h22: dec.ctrl = 4'd6;
               6'h24: dec.ctrl = 4'd0;
               6'h25: dec.ctrl = 4'd1;
               6'h2A: dec.ctrl = 4'd7;
               6'h27: dec.ctrl = 4'd12;
               6'h03: begin
                  dec.ctrl      = 4'd8;
                  dec.shamt_sel = 1'b1;
               end
               6'h07: dec.ctrl = 4'd8;
               default: begin
                  dec.reg_write = 1'b0;
                  dec.illegal   = 1'b1;
               end
            endcase
         end
         6'h08, 6'h23: begin
            dec.ctrl      = 4'd2;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         6'h0A: begin
            dec.ctrl      = 4'd7;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         6'h0F: begin
            dec.ctrl      = 4'd9;
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         6'h2B: begin
            dec.ctrl    = 4'd2;
            dec.alu_src = 1'b1;
         end
         6'h04: begin
            dec.ctrl   = 4'd6;
            dec.branch = 1'b1;
         end
         6'h05: begin
            dec.ctrl   = 4'd6;
            dec.branch = 1'b1;
            dec.btype  = 2'd1;
         end
         6'h01: begin
            dec.ctrl   = 4'd7;
            dec.branch = 1'b1;
            dec.btype  = 2'd2;
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Flush overrides the state but not the data registers: with the state
   // forced to S_EMPTY the stale data is never presented as valid.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         S_EMPTY: begin
            if (accept) begin
               state_d = S_ONE;
               out_d   = dec;
            end
         end
         S_ONE: begin
            if (consume && accept) begin
               out_d = dec;
            end else if (consume) begin
               state_d = S_EMPTY;
            end else if (accept) begin
               state_d = S_FULL;
               skid_d  = dec;
            end
         end
         S_FULL: begin
            if (consume) begin
               state_d = S_ONE;
               out_d   = skid_q;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      if (flush_i) begin
         state_d = S_EMPTY;
      end
   end

   // Counts on accept even when the entry is later flushed.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && dec.illegal && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      out_valid_o   = (state_q != S_EMPTY);
      in_ready_o    = (state_q != S_FULL);
      alu_ctrl_o    = out_q.ctrl;
      alu_src_o     = out_q.alu_src;
      shamt_sel_o   = out_q.shamt_sel;
      reg_write_o   = out_q.reg_write;
      branch_o      = out_q.branch;
      branch_type_o = out_q.btype;
      illegal_o     = out_q.illegal;
      illegal_cnt_o = cnt_q;
   end

endmodule

// File: tb/tb_alu_decode_pipe.sv
module tb_alu_decode_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] instr_i = '0;
   logic        flush_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [3:0]  alu_ctrl_o;
   logic        alu_src_o;
   logic        shamt_sel_o;
   logic        reg_write_o;
   logic        branch_o;
   logic [1:0]  branch_type_o;
   logic        illegal_o;
   logic [7:0]  illegal_cnt_o;

   alu_decode_pipe #(.CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instr_i(instr_i),
      .flush_i(flush_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .alu_ctrl_o(alu_ctrl_o), .alu_src_o(alu_src_o), .shamt_sel_o(shamt_sel_o),
      .reg_write_o(reg_write_o), .branch_o(branch_o), .branch_type_o(branch_type_o),
      .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Expected record: {ctrl[3:0], alu_src, shamt_sel, reg_write, branch, btype[1:0], illegal}
   typedef struct {
      logic [31:0] instr;
      logic [10:0] exp;
   } vec_t;

   int          errors = 0;
   int          checks = 0;
   logic [10:0] sb_q[$];
   logic [10:0] exp_in = '0;
   int          cnt_exp = 0;
   vec_t        tbl[18];
   logic [10:0] dut_vec;

   assign dut_vec = {alu_ctrl_o, alu_src_o, shamt_sel_o, reg_write_o, branch_o, branch_type_o, illegal_o};

   function automatic logic [10:0] e(input logic [3:0] c, input logic [6:0] f);
      return {c, f};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [10:0] ex);
      in_valid_i = 1'b1;
      instr_i    = ins;
      exp_in     = ex;
   endtask

   // Scoreboard: push on accept, pop and compare on consume.
   always @(negedge clk_i) begin
      if (rst_i) begin
         if (in_valid_i && in_ready_o && exp_in[0] && cnt_exp != 255) cnt_exp++;
         if (flush_i) begin
            sb_q.delete();
         end else begin
            if (out_valid_o && out_ready_i) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected: got %0h expected nothing at %0t", dut_vec, $time);
               end else begin
                  chk("sb_out", {21'd0, dut_vec}, {21'd0, sb_q.pop_front()});
               end
            end
            if (in_valid_i && in_ready_o) sb_q.push_back(exp_in);
         end
      end
   end

   initial begin
      int ok;
      tbl[0]  = '{32'h012A4020, e(4'd2,  7'b0010000)};  // add
      tbl[1]  = '{32'h00021943, e(4'd8,  7'b0110000)};  // sra
      tbl[2]  = '{32'h3C011234, e(4'd9,  7'b1010000)};  // lui
      tbl[3]  = '{32'h11090004, e(4'd6,  7'b0001000)};  // beq
      tbl[4]  = '{32'h012A4022, e(4'd6,  7'b0010000)};  // sub
      tbl[5]  = '{32'h012A4024, e(4'd0,  7'b0010000)};  // and
      tbl[6]  = '{32'h012A4025, e(4'd1,  7'b0010000)};  // or
      tbl[7]  = '{32'h012A402A, e(4'd7,  7'b0010000)};  // slt
      tbl[8]  = '{32'h012A4027, e(4'd12, 7'b0010000)};  // nor
      tbl[9]  = '{32'h012A4007, e(4'd8,  7'b0010000)};  // srav
      tbl[10] = '{32'h21280005, e(4'd2,  7'b1010000)};  // addi
      tbl[11] = '{32'h29280005, e(4'd7,  7'b1010000)};  // slti
      tbl[12] = '{32'h8D280004, e(4'd2,  7'b1010000)};  // lw
      tbl[13] = '{32'hAD280004, e(4'd2,  7'b1000000)};  // sw
      tbl[14] = '{32'h15090004, e(4'd6,  7'b0001010)};  // bne
      tbl[15] = '{32'h05000004, e(4'd7,  7'b0001100)};  // bltz
      tbl[16] = '{32'h012A4021, e(4'd0,  7'b0000001)};  // R-type, unknown funct
      tbl[17] = '{32'hFC000000, e(4'd0,  7'b0000001)};  // unknown opcode

      // Reset state
      #12;
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_dec", dut_vec, 0);
      chk("rst_cnt", illegal_cnt_o, 0);
      #10 rst_i = 1'b1;
      step();
      chk("rst_in_ready", in_ready_o, 1);

      // First add: one-cycle latency
      out_ready_i = 1'b1;
      drive(tbl[0].instr, tbl[0].exp);
      step();
      in_valid_i = 1'b0;
      chk("add_valid", out_valid_o, 1);
      chk("add_ctrl", alu_ctrl_o, 2);
      chk("add_regw", reg_write_o, 1);
      chk("add_src", alu_src_o, 0);
      step();
      step();

      // Whole table back-to-back; one result per cycle
      for (int i = 1; i < 18; i++) begin
         drive(tbl[i].instr, tbl[i].exp);
         step();
         chk("stream_valid", out_valid_o, 1);
         chk("stream_ready", in_ready_o, 1);
      end
      in_valid_i = 1'b0;
      step();
      step();
      chk("stream_drained", sb_q.size(), 0);
      chk("cnt_after_table", illegal_cnt_o, cnt_exp);
      chk("cnt_two", illegal_cnt_o, 2);

      // Execute stalls for three cycles while three instructions are offered
      out_ready_i = 1'b0;
      drive(tbl[4].instr, tbl[4].exp);
      step();
      chk("stall_ready1", in_ready_o, 1);
      drive(tbl[5].instr, tbl[5].exp);
      step();
      chk("stall_ready2", in_ready_o, 0);
      drive(tbl[6].instr, tbl[6].exp);
      step();
      chk("stall_hold_ready", in_ready_o, 0);
      chk("stall_hold_ctrl", alu_ctrl_o, 6);
      chk("stall_hold_valid", out_valid_o, 1);
      out_ready_i = 1'b1;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         if (in_ready_o) begin
            step();
            ok = 1;
            break;
         end
         step();
      end
      chk("stall_third_accepted", ok, 1);
      in_valid_i = 1'b0;
      step();
      step();
      chk("stall_drained", sb_q.size(), 0);
      chk("stall_idle", out_valid_o, 0);

      // Flush while FULL with a new instruction on the input
      out_ready_i = 1'b0;
      drive(tbl[7].instr, tbl[7].exp);
      step();
      drive(tbl[8].instr, tbl[8].exp);
      step();
      chk("flush_pre_full", in_ready_o, 0);
      drive(tbl[9].instr, tbl[9].exp);
      flush_i = 1'b1;
      step();
      flush_i    = 1'b0;
      in_valid_i = 1'b0;
      chk("flush_valid", out_valid_o, 0);
      chk("flush_ready", in_ready_o, 1);
      out_ready_i = 1'b1;
      repeat (3) step();
      chk("flush_no_output", out_valid_o, 0);

      // 260 illegal instructions: counter saturates
      for (int i = 0; i < 260; i++) begin
         drive(32'hFC000000, e(4'd0, 7'b0000001));
         step();
      end
      in_valid_i = 1'b0;
      step();
      step();
      chk("sat_drained", sb_q.size(), 0);
      chk("sat_cnt", illegal_cnt_o, 255);
      chk("sat_cnt_model", illegal_cnt_o, cnt_exp);

      // Asynchronous reset mid-cycle while FULL
      out_ready_i = 1'b0;
      drive(tbl[10].instr, tbl[10].exp);
      step();
      drive(tbl[11].instr, tbl[11].exp);
      step();
      in_valid_i = 1'b0;
      chk("arst_pre_full", in_ready_o, 0);
      #2;
      rst_i = 1'b0;
      sb_q.delete();
      cnt_exp = 0;
      #1;
      chk("arst_valid", out_valid_o, 0);
      chk("arst_cnt", illegal_cnt_o, 0);
      chk("arst_dec", dut_vec, 0);
      #3 rst_i = 1'b1;
      step();
      chk("arst_ready", in_ready_o, 1);
      chk("arst_valid_after", out_valid_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_decode_pipe.md
Name: alu_decode_pipe

Overview:
- Registered instruction-to-ALU-control decode stage for the pipelined MIPS datapath.
- Accepts 32-bit instructions over a valid/ready handshake and decodes each to the 4-bit ALU control code plus datapath selects.
- Presents the result to the execute stage through a 2-entry buffer (output register + skid register), so a full-throughput upstream never loses an instruction when execute stalls.

Parameters:
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  instr_i holds a valid instruction.
- in_ready_o  output  1  stage can accept; equals "skid register empty".
- instr_i  input  32  MIPS instruction.
- flush_i  input  1  synchronous kill of all buffered entries (branch taken).
- out_valid_o  output  1  decoded entry present at the outputs.
- out_ready_i  input  1  execute stage consumes the entry this cycle.
- alu_ctrl_o  output  4  ALU control: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 SRA, 9 LUI, 12 NOR.
- alu_src_o  output  1  1 = immediate operand.
- shamt_sel_o  output  1  1 = src1 is the shamt field.
- reg_write_o  output  1  writes the register file.
- branch_o  output  1  branch instruction.
- branch_type_o  output  2  0 beq, 1 bne, 2 bltz.
- illegal_o  output  1  opcode/funct not in the table.
- illegal_cnt_o  output  CNT_W  count of illegal instructions accepted; saturates at all-ones.

Behaviour:
- Reset (rst_i low, asynchronous):
  - out_valid_o, all decoded outputs and illegal_cnt_o go to 0.
  - Skid register is emptied, so in_ready_o = 1 once reset is released.
- Decode table (opcode / funct -> ctrl, alu_src, shamt_sel, reg_write, branch, branch_type). Fields not listed are 0.
  - R-type, op 0x00:
    - funct 0x20 -> 2, reg_write
    - funct 0x22 -> 6, reg_write
    - funct 0x24 -> 0, reg_write
    - funct 0x25 -> 1, reg_write
    - funct 0x2A -> 7, reg_write
    - funct 0x27 -> 12, reg_write
    - funct 0x03 -> 8, shamt_sel, reg_write
    - funct 0x07 -> 8, reg_write
  - I-type:
    - op 0x08 -> 2, alu_src, reg_write
    - op 0x0A -> 7, alu_src, reg_write
    - op 0x0F -> 9, alu_src, reg_write
    - op 0x23 -> 2, alu_src, reg_write
    - op 0x2B -> 2, alu_src
  - Branches:
    - op 0x04 -> 6, branch, type 0
    - op 0x05 -> 6, branch, type 1
    - op 0x01 -> 7, branch, type 2
  - Anything else -> ctrl 0, illegal_o = 1, all other controls 0.
- Handshakes:
  - Accept = in_valid_i & in_ready_o.
  - Consume = out_valid_o & out_ready_i.
- Latency: 1 cycle. An instruction accepted in cycle N appears at the outputs in N+1 when the output register is empty or being consumed.
- Buffer states:
  - EMPTY (out_valid_o = 0):
    - Accept -> ONE.
  - ONE (output register full, skid empty):
    - Consume with no accept -> EMPTY.
    - Consume and accept -> ONE, output register replaced.
    - Accept with no consume -> FULL; the new entry goes to the skid register.
  - FULL (skid full, in_ready_o = 0):
    - Consume -> ONE; skid moves to the output register in the same edge.
- Ordering: strict FIFO order is preserved.
- Outputs hold stable while out_valid_o = 1 and out_ready_i = 0.
- flush_i:
  - Next state is EMPTY regardless of accept or consume in the same cycle.
  - An instruction presented in the flush cycle is dropped.
  - illegal_cnt_o is not affected.
- Illegal counter:
  - Increments on accept of an illegal instruction, including one later flushed.
  - Holds at 2^CNT_W - 1.
- Reset mid-operation: buffered entries are discarded immediately; no partial outputs.
- Decoded outputs are registered, not combinational from instr_i.

Test Plan:
- Reset then accept 0x012A4020 (add) with out_ready_i = 1 -> next cycle:
  - out_valid_o = 1, alu_ctrl_o = 2, reg_write_o = 1, alu_src_o = 0.
- Back-to-back:
  - Send sra (funct 0x03) -> ctrl 8, shamt_sel_o = 1.
  - Then lui 0x3C011234 -> ctrl 9, alu_src_o = 1.
  - Then beq -> ctrl 6, branch_o = 1, type 0.
  - Required: one result per cycle.
- out_ready_i = 0 for 3 cycles while sending 3 instructions:
  - in_ready_o drops after the 2nd is accepted.
  - 3rd is held upstream.
  - On release, the outputs drain in order 1, 2, 3 with no loss or duplication.
- flush_i asserted while FULL and in_valid_i = 1:
  - Next cycle out_valid_o = 0 and in_ready_o = 1.
  - The flushed instructions never appear.
- Illegal instruction 0xFC000000 accepted 260 times with CNT_W = 8:
  - illegal_o = 1 each time, alu_ctrl_o = 0.
  - illegal_cnt_o saturates at 255.
- rst_i pulsed low asynchronously mid-cycle while FULL:
  - out_valid_o = 0 and illegal_cnt_o = 0 immediately, without waiting for a clock edge.
  - in_ready_o = 1 after release.
